// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on an accepted start, added one bit
// per clock from the LSB, and the completed sum/carry are published together.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic             busy_reg, done_reg;

  logic bit_sum, bit_carry;

  assign bit_sum   = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign bit_carry = (a_sh_reg[0] & b_sh_reg[0]) | (a_sh_reg[0] & carry_reg) |
                     (b_sh_reg[0] & carry_reg);

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    res_next   = res_reg;
    sum_next   = sum_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          a_sh_next  = a;
          b_sh_next  = b;
          carry_next = 1'b0;
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        // result enters at the MSB so bit i lands at position i after WIDTH shifts
        res_next   = {bit_sum, res_reg[WIDTH-1:1]};
        a_sh_next  = a_sh_reg >> 1;
        b_sh_next  = b_sh_reg >> 1;
        carry_next = bit_carry;
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == LAST_BIT) begin
          sum_next   = {bit_sum, res_reg[WIDTH-1:1]};
          cout_next  = bit_carry;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      res_reg   <= res_next;
      sum_reg   <= sum_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      busy_reg  <= (state_next == RUN);
      done_reg  <= (state_next == DONE);
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder; expected results come from
// plain integer addition and the cycle timing implied by the operand width.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;

  logic [7:0] last_sum  = '0;
  logic       last_cout = 1'b0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues start in this cycle, optionally re-pulses start
  // during RUN cycle rp, and returns at the negedge of the done cycle.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input int rp);
    logic [8:0] total;
    total = {1'b0, x} + {1'b0, y};
    start = 1'b1; a = x; b = y;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("sum_hold", sum, last_sum);
      check("cout_hold", cout, last_cout);
      start = (i == rp);
      a = (i == rp) ? 8'hFF : 8'($urandom);
      b = (i == rp) ? 8'hFF : 8'($urandom);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("sum", sum, total[7:0]);
    check("cout", cout, total[8]);
    $display("op a=%02h b=%02h -> sum=%02h cout=%0d (exp %02h %0d)",
             x, y, sum, cout, total[7:0], total[8]);
    last_sum  = total[7:0];
    last_cout = total[8];
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("done_idle", done, 0);
    check("busy_idle", busy, 0);
    check("sum_idle", sum, last_sum);
  endtask

  initial begin
    logic [4:0] total4;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge clk);

    run_op(8'h00, 8'h00, 0); idle_check();
    run_op(8'hFF, 8'h01, 0); idle_check();
    run_op(8'hA5, 8'h5A, 0); idle_check();
    run_op(8'h3C, 8'h0F, 3); idle_check();

    // Abort with reset during RUN cycle 4
    start = 1'b1; a = 8'h77; b = 8'h66;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("busy_pre_abort", busy, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_sum = '0; last_cout = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    run_op(8'h80, 8'h80, 0);
    idle_check();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_done_after", done, 0);
    end

    // Back-to-back: next start issued in the DONE cycle
    run_op(8'h12, 8'h34, 0);
    run_op(8'hF0, 8'h1F, 0);
    run_op(8'hC3, 8'h99, 0);
    idle_check();

    for (int n = 0; n < 20; n++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 9)));
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    // Narrow instance
    start4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    total4 = {1'b0, a4} + {1'b0, b4};
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
      check("w4_busy", busy4, 1);
      check("w4_done_run", done4, 0);
    end
    @(negedge clk);
    check("w4_done", done4, 1);
    check("w4_sum", sum4, total4[3:0]);
    check("w4_cout", cout4, total4[4]);
    $display("op4 a=F b=F -> sum=%0h cout=%0d", sum4, cout4);
    @(negedge clk);
    check("w4_done_clear", done4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  request to begin an addition, sampled on rising clk.
REQ-005 The block SHALL have port a  input  WIDTH  first operand, sampled only on an accepted start.
REQ-006 The block SHALL have port b  input  WIDTH  second operand, sampled only on an accepted start.
REQ-007 The block SHALL have port busy  output  1  high while bit-serial computation is in progress.
REQ-008 The block SHALL have port done  output  1  single-cycle pulse marking valid sum/cout.
REQ-009 The block SHALL have port sum  output  WIDTH  registered result, a+b modulo 2^WIDTH.
REQ-010 The block SHALL have port cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN, DONE; all outputs registered.
REQ-012 A start is accepted when sampled high while state is IDLE or DONE; start in RUN SHALL be ignored with no effect on operands, count or outputs.
REQ-013 On an accepted start the block SHALL load a and b into internal shift registers, clear the carry flop to 0, clear the bit counter to 0, and enter RUN.
REQ-014 In RUN, each cycle SHALL compute one result bit from the operand LSBs and the carry flop: bit = a0 XOR b0 XOR c; next c = majority(a0, b0, c); operands shift right by one.
REQ-015 Result bits SHALL be shifted into an internal result register from the MSB end so that after WIDTH cycles bit i of the operands maps to bit i of the result.
REQ-016 RUN SHALL last exactly WIDTH cycles; busy SHALL be 1 for exactly those WIDTH cycles and 0 otherwise.
REQ-017 On the edge ending the last RUN cycle the block SHALL load sum with the result register and cout with the final carry, and enter DONE.
REQ-018 done SHALL be 1 exactly while in DONE (one cycle); DONE SHALL return to IDLE next cycle unless a start is accepted, in which case it enters RUN (back-to-back, no idle gap).
REQ-019 Latency: start accepted at edge k -> busy high cycles k+1..k+WIDTH -> done high and sum/cout valid in cycle k+WIDTH+1.
REQ-020 sum and cout SHALL hold their last completed values in IDLE, RUN and DONE until the next completion; partial results SHALL never be visible on sum.
REQ-021 Operand changes on a/b after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-022 When rst is high at a rising edge the block SHALL enter IDLE with busy=0, done=0, sum=0, cout=0, carry flop, counter and shift registers cleared.
REQ-023 rst SHALL take priority over start; rst asserted during RUN SHALL abort the operation with no done pulse and no update of sum/cout beyond the reset values.
REQ-024 A start sampled in the first cycle after rst deasserts SHALL be accepted normally.

Verification
REQ-025 WIDTH=8, start with a=0x00 b=0x00 -> busy 8 cycles, done pulse at cycle 9 after start, sum=0x00 cout=0.
REQ-026 WIDTH=8, a=0xFF b=0x01 -> sum=0x00 cout=1; a=0xA5 b=0x5A -> sum=0xFF cout=0.
REQ-027 WIDTH=8, a=0x3C b=0x0F accepted, start re-pulsed with a=0xFF b=0xFF on RUN cycle 3 -> ignored, result sum=0x4B cout=0 at cycle 9.
REQ-028 WIDTH=8, rst pulsed on RUN cycle 4 -> busy=0 next cycle, no done, sum=0x00 cout=0; subsequent start a=0x80 b=0x80 -> sum=0x00 cout=1.
REQ-029 Back-to-back: start held high through DONE -> second operation begins with no IDLE cycle, done pulses spaced WIDTH+1 cycles apart, each result correct.
REQ-030 WIDTH=4, a=0xF b=0xF -> sum=0xE cout=1, done at cycle 5 after start.
